// File: rtl/dcache_pkg.sv
// Shared constants, state encodings and address-field helpers for the data cache.
package dcache_pkg;

  localparam int LINE_WORDS_LOG_DEF = 2;
  localparam int SET_ADDR_LEN_DEF   = 3;
  localparam int ADDR_LEN_DEF       = 32;
  localparam int LINE_WORDS         = 1 << LINE_WORDS_LOG_DEF;

  // Controller states; plain constants so older flows can consume them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  // Tag bits left over once byte, word and set fields are removed.
  function automatic int tag_width(input int addr_len, input int set_len, input int lw_log);
    return addr_len - set_len - lw_log - 2;
  endfunction

  // Extract width bits starting at lsb; callers cast down to the field width.
  function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
    return (a >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Cache storage: per-set valid/dirty/tag plus a byte-writable data array with asynchronous word read.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SET_W  = 3,
  parameter int WORD_W = 2,
  parameter int TAG_W  = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SET_W-1:0]  set_idx,
  input  logic [WORD_W-1:0] word_idx,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data,
  input  logic              mark_dirty,
  input  logic              fill_done,
  input  logic [TAG_W-1:0]  fill_tag,
  output logic              line_valid,
  output logic              line_dirty,
  output logic [TAG_W-1:0]  line_tag,
  output logic [31:0]       rd_word
);

  localparam int SETS  = 1 << SET_W;
  localparam int DEPTH = SETS << WORD_W;

  logic [SETS-1:0]         valid_q, valid_d;
  logic [SETS-1:0]         dirty_q, dirty_d;
  logic [TAG_W-1:0]        tag_mem [SETS];
  logic [SET_W+WORD_W-1:0] data_idx;

  assign data_idx   = {set_idx, word_idx};
  assign line_valid = valid_q[set_idx];
  assign line_dirty = dirty_q[set_idx];
  assign line_tag   = tag_mem[set_idx];

  // Line status updates: a store hit dirties the line, a completed refill makes it valid and clean.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (mark_dirty) begin
      dirty_d[set_idx] = 1'b1;
    end
    if (fill_done) begin
      valid_d[set_idx] = 1'b1;
      dirty_d[set_idx] = 1'b0;
    end
  end

  // Status flops; reset invalidates every line so an interrupted refill is never trusted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag store written when a refill finishes; contents only matter while valid.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[set_idx] <= fill_tag;
    end
  end

  // One memory per byte lane gives per-byte write enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    // Byte-lane write from store hit or refill beat.
    always_ff @(posedge clk) begin
      if (wr_be[gi]) begin
        lane_mem[data_idx] <= wr_data[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = lane_mem[data_idx];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller for the MEM stage.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS_LOG = LINE_WORDS_LOG_DEF,
  parameter int SET_ADDR_LEN   = SET_ADDR_LEN_DEF,
  parameter int ADDR_LEN       = ADDR_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_en,
  input  logic [3:0]          wr_be,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic                miss,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int TAG_W    = tag_width(ADDR_LEN, SET_ADDR_LEN, LINE_WORDS_LOG);
  localparam int WORD_LSB = 2;
  localparam int SET_LSB  = LINE_WORDS_LOG + 2;
  localparam int TAG_LSB  = SET_LSB + SET_ADDR_LEN;

  logic [1:0]                state_q, state_d;
  logic [LINE_WORDS_LOG-1:0] beat_q, beat_d;
  logic                      retry_q, retry_d;
  logic [31:0]               hit_cnt_q, hit_cnt_d;
  logic [31:0]               miss_cnt_q, miss_cnt_d;

  logic [63:0]               addr_ext;
  logic [LINE_WORDS_LOG-1:0] addr_word;
  logic [SET_ADDR_LEN-1:0]   set_idx;
  logic [TAG_W-1:0]          req_tag;

  logic                      line_valid, line_dirty;
  logic [TAG_W-1:0]          line_tag;
  logic [31:0]               arr_word;
  logic [LINE_WORDS_LOG-1:0] arr_word_idx;
  logic [3:0]                arr_be;
  logic [31:0]               arr_wdata;

  logic is_idle, is_wb, is_fill;
  logic store_req, request, line_hit, hit;
  logic mark_dirty, fill_beat, fill_done, last_beat;

  assign addr_ext  = 64'(addr);
  assign addr_word = LINE_WORDS_LOG'(addr_field(addr_ext, WORD_LSB, LINE_WORDS_LOG));
  assign set_idx   = SET_ADDR_LEN'(addr_field(addr_ext, SET_LSB, SET_ADDR_LEN));
  assign req_tag   = TAG_W'(addr_field(addr_ext, TAG_LSB, TAG_W));

  assign is_idle   = (state_q == ST_IDLE);
  assign is_wb     = (state_q == ST_WB);
  assign is_fill   = (state_q == ST_FILL);
  assign store_req = |wr_be;
  assign request   = rd_en | store_req;
  assign line_hit  = line_valid & (line_tag == req_tag);
  assign hit       = is_idle & request & line_hit;
  assign last_beat = &beat_q;
  assign fill_beat = is_fill & mem_ack;
  assign fill_done = fill_beat & last_beat;
  assign mark_dirty = hit & store_req;

  // The array port follows the request word while idle and the beat counter during line transfers.
  always_comb begin
    arr_word_idx = is_idle ? addr_word : beat_q;
    arr_be       = 4'h0;
    arr_wdata    = wr_data;
    if (mark_dirty) begin
      arr_be = wr_be;
    end else if (fill_beat) begin
      arr_be    = 4'hF;
      arr_wdata = mem_rdata;
    end
  end

  dcache_array #(
    .SET_W  (SET_ADDR_LEN),
    .WORD_W (LINE_WORDS_LOG),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_idx    (set_idx),
    .word_idx   (arr_word_idx),
    .wr_be      (arr_be),
    .wr_data    (arr_wdata),
    .mark_dirty (mark_dirty),
    .fill_done  (fill_done),
    .fill_tag   (req_tag),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .rd_word    (arr_word)
  );

  // Pipeline-facing and memory-facing outputs; everything memory-side is zero while idle.
  always_comb begin
    rd_data   = (is_idle & line_hit) ? arr_word : 32'd0;
    miss      = (is_idle & request & ~line_hit) | ~is_idle;
    mem_req   = is_wb | is_fill;
    mem_we    = is_wb;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (is_wb) begin
      mem_addr  = {line_tag, set_idx, beat_q, 2'b00};
      mem_wdata = arr_word;
    end else if (is_fill) begin
      mem_addr  = {req_tag, set_idx, beat_q, 2'b00};
    end
  end

  // Next-state logic: miss dispatch, word-serial beats, retry flag and event counters.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (retry_q) begin
            retry_d = 1'b0;
          end else begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
        end else if (request) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          beat_d     = '0;
          state_d    = (line_valid & line_dirty) ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            retry_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Controller state flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
